// File: rtl/alu_param_pkg.sv
// -----------------------------------------------------------------------------
// alu_param_pkg
// Shared definitions for the alu_param block:
//   OP_W     - opcode width in bits
//   op_e     - opcode encoding (OP_ADD .. OP_MAX)
//   state_e  - request/result handshake FSM states
// -----------------------------------------------------------------------------
package alu_param_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_NOT  = 3'b011,
    OP_XOR  = 3'b100,
    OP_ABS  = 3'b101,
    OP_HSUB = 3'b110,
    OP_MAX  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk_p_i    clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   start      one-cycle pulse; the first iteration runs in the start cycle
//   a, b       operands, must stay stable while the multiply is running
//   done       high in the cycle performing the last (WIDTH-th) iteration
//   product    2*WIDTH-bit result, valid while done is high
// -----------------------------------------------------------------------------
module alu_mul_seq
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_p_i,
  input  logic               reset_n_i,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  logic [DW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [DW-1:0]    acc_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;

  logic             active_s;
  logic [DW-1:0]    mcand_s;
  logic [WIDTH-1:0] mplier_s;
  logic [DW-1:0]    acc_s;
  logic [CW-1:0]    cnt_s;
  logic [DW-1:0]    acc_nxt_s;
  logic             done_s;

  // Working operands: a start cycle begins from fresh operands, later cycles from the registers.
  always_comb begin
    active_s = start || busy_r;
    if (start) begin
      mcand_s  = {{WIDTH{1'b0}}, a};
      mplier_s = b;
      acc_s    = {DW{1'b0}};
      cnt_s    = {CW{1'b0}};
    end else begin
      mcand_s  = mcand_r;
      mplier_s = mplier_r;
      acc_s    = acc_r;
      cnt_s    = cnt_r;
    end
    if (mplier_s[0]) begin
      acc_nxt_s = acc_s + mcand_s;
    end else begin
      acc_nxt_s = acc_s;
    end
    done_s = active_s && (cnt_s == CW'(WIDTH - 1));
  end

  // Iteration state: shift multiplicand left, multiplier right, count processed bits.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mcand_r  <= {DW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {DW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
    end else if (active_s) begin
      mcand_r  <= mcand_s << 1'b1;
      mplier_r <= mplier_s >> 1'b1;
      acc_r    <= acc_nxt_s;
      cnt_r    <= cnt_s + CW'(1);
      busy_r   <= ~done_s;
    end else begin
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      acc_r    <= acc_r;
      cnt_r    <= cnt_r;
      busy_r   <= busy_r;
    end
  end

  assign done    = done_s;
  assign product = acc_nxt_s;

endmodule

// File: rtl/alu_param.sv
// -----------------------------------------------------------------------------
// alu_param
// Parameterised ALU with valid/ready request and result handshakes.
// Build option: define ALU_PARAM_MUL_EN to include the iterative multiplier
// (opcode MUL, WIDTH+1 cycle latency). Without it, MUL completes in one cycle
// with data_o = 0 and err_o = 1.
// Ports:
//   clk_p_i      clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   in_valid_i   request valid          in_ready_o   accepting (IDLE only)
//   data_a_i     operand A              data_b_i     operand B
//   inst_i       opcode (op_e)
//   out_valid_o  result valid (DONE)    out_ready_i  consumer accepts result
//   data_o       2*WIDTH-bit result     err_o        unsupported opcode
// -----------------------------------------------------------------------------
module alu_param
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_p_i,
  input  logic               reset_n_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   data_a_i,
  input  logic [WIDTH-1:0]   data_b_i,
  input  logic [OP_W-1:0]    inst_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] data_o,
  output logic               err_o
);

  localparam int DW = 2 * WIDTH;

  state_e           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [OP_W-1:0]  op_r;
  logic [DW-1:0]    data_r;
  logic             err_r;
  logic             mul_start_r;

  logic [DW-1:0]    az_s;
  logic [DW-1:0]    bz_s;
  logic [DW-1:0]    sub_s;
  logic [WIDTH-1:0] abs_s;
  logic [DW-1:0]    result_s;
  logic             err_s;
  logic             is_mul_s;
  logic             mul_done_s;
  logic [DW-1:0]    mul_product_s;
  logic             unused_s;

`ifdef ALU_PARAM_MUL_EN
  assign is_mul_s = (inst_i == OP_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_p_i   (clk_p_i),
    .reset_n_i (reset_n_i),
    .start     (mul_start_r),
    .a         (a_r),
    .b         (b_r),
    .done      (mul_done_s),
    .product   (mul_product_s)
  );

  // The captured opcode is only kept for observability in this build.
  assign unused_s = ^op_r;
`else
  assign is_mul_s      = 1'b0;
  assign mul_done_s    = 1'b0;
  assign mul_product_s = {DW{1'b0}};

  // Captured operands have no consumer when the multiplier is absent.
  assign unused_s = ^{a_r, b_r, op_r, mul_start_r};
`endif

  // Single-cycle datapath, evaluated on the request inputs so the result is
  // registered on the accepting edge.
  always_comb begin
    az_s     = {{WIDTH{1'b0}}, data_a_i};
    bz_s     = {{WIDTH{1'b0}}, data_b_i};
    sub_s    = bz_s - az_s;
    // Two's complement negate; the most negative value maps onto itself,
    // which read as unsigned is exactly its magnitude.
    if (data_a_i[WIDTH-1]) begin
      abs_s = ~data_a_i + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      abs_s = data_a_i;
    end
    result_s = {DW{1'b0}};
    err_s    = 1'b0;
    case (inst_i)
      OP_ADD:  result_s = az_s + bz_s;
      OP_SUB:  result_s = sub_s;
      OP_MUL: begin
`ifdef ALU_PARAM_MUL_EN
        result_s = {DW{1'b0}};
        err_s    = 1'b0;
`else
        result_s = {DW{1'b0}};
        err_s    = 1'b1;
`endif
      end
      OP_NOT:  result_s = {{WIDTH{1'b0}}, ~data_a_i};
      OP_XOR:  result_s = {{WIDTH{1'b0}}, data_a_i ^ data_b_i};
      OP_ABS:  result_s = {{WIDTH{1'b0}}, abs_s};
      OP_HSUB: result_s = {sub_s[DW-1], sub_s[DW-1:1]};
      OP_MAX: begin
        if (data_a_i > data_b_i) begin
          result_s = az_s;
        end else begin
          result_s = bz_s;
        end
      end
      default: begin
        result_s = {DW{1'b0}};
        err_s    = 1'b0;
      end
    endcase
  end

  // Handshake FSM with operand capture and registered result/error.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= ST_IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= {OP_W{1'b0}};
      data_r      <= {DW{1'b0}};
      err_r       <= 1'b0;
      mul_start_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_r  <= data_a_i;
            b_r  <= data_b_i;
            op_r <= inst_i;
            if (is_mul_s) begin
              state_r     <= ST_EXEC;
              mul_start_r <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              data_r  <= result_s;
              err_r   <= err_s;
            end
          end
        end
        ST_EXEC: begin
          mul_start_r <= 1'b0;
          if (mul_done_s) begin
            state_r <= ST_DONE;
            data_r  <= mul_product_s;
            err_r   <= 1'b0;
          end
        end
        ST_DONE: begin
          // Result registers are untouched here, so they stay stable under back-pressure.
          if (out_ready_i) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          mul_start_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_r == ST_IDLE);
  assign out_valid_o = (state_r == ST_DONE);
  assign data_o      = data_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_alu_param.sv
module tb_alu_param;

  localparam int W  = 8;
  localparam int DW = 16;
`ifdef ALU_PARAM_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk_p_i = 1'b0;
  logic          reset_n_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  data_a_i;
  logic [W-1:0]  data_b_i;
  logic [2:0]    inst_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] data_o;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] d;
    logic        e;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[14];

  always #5 clk_p_i = ~clk_p_i;

  alu_param #(.WIDTH(W)) dut (
    .clk_p_i     (clk_p_i),
    .reset_n_i   (reset_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_a_i    (data_a_i),
    .data_b_i    (data_b_i),
    .inst_i      (inst_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .err_o       (err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions. Returns {err, data}.
  function automatic logic [16:0] model(input int a, input int b, input int op);
    int s;
    int r;
    bit e;
    e = 1'b0;
    case (op)
      0: r = a + b;
      1: r = (b - a) & 32'hFFFF;
      2: begin
        if (MUL_EN) r = a * b;
        else begin r = 0; e = 1'b1; end
      end
      3: r = 255 - a;
      4: r = a ^ b;
      5: r = (a >= 128) ? 256 - a : a;
      6: begin s = b - a; r = (s >>> 1) & 32'hFFFF; end
      7: r = (a > b) ? a : b;
      default: r = 0;
    endcase
    model = {e, r[15:0]};
  endfunction

  function automatic int model_lat(input int op);
    model_lat = (op == 2 && MUL_EN) ? W + 1 : 1;
  endfunction

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [15:0] exp_d, input logic exp_e,
                        input int exp_lat, input int hold);
    int lat;
    int waitc;
    bit busy_ok;
    bit stable_ok;
    waitc = 0;
    while (!in_ready_o && waitc < 40) begin
      @(posedge clk_p_i); #1;
      waitc++;
    end
    check({tag, " ready"}, in_ready_o, 1);
    data_a_i   = a;
    data_b_i   = b;
    inst_i     = op;
    in_valid_i = 1'b1;
    @(posedge clk_p_i); #1;
    in_valid_i = 1'b0;
    data_a_i   = $urandom;
    data_b_i   = $urandom;
    inst_i     = $urandom;
    lat        = 1;
    busy_ok    = 1'b1;
    while (!out_valid_o && lat < 40) begin
      if (in_ready_o) busy_ok = 1'b0;
      @(posedge clk_p_i); #1;
      lat++;
    end
    if (in_ready_o) busy_ok = 1'b0;
    check({tag, " busy_not_ready"}, busy_ok, 1);
    check({tag, " out_valid"}, out_valid_o, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, data_o, exp_d);
    check({tag, " err"}, err_o, exp_e);
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid_i = 1'b1;
      data_a_i   = $urandom;
      data_b_i   = $urandom;
      inst_i     = $urandom;
      @(posedge clk_p_i); #1;
      if (!out_valid_o || in_ready_o || data_o !== exp_d || err_o !== exp_e) stable_ok = 1'b0;
    end
    if (hold > 0) check({tag, " hold_stable"}, stable_ok, 1);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_p_i); #1;
    out_ready_i = 1'b0;
    check({tag, " after_handshake"}, {in_ready_o, out_valid_o}, 2'b10);
  endtask

  initial begin
    logic [16:0] m;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [2:0]  rop;
    bit          seen;

    tbl[0]  = '{8'hFF, 8'h01, 3'd0, 16'h0100, 1'b0, 1, 0};
    tbl[1]  = '{8'h05, 8'h03, 3'd1, 16'hFFFE, 1'b0, 1, 0};
    tbl[2]  = '{8'h05, 8'h03, 3'd6, 16'hFFFF, 1'b0, 1, 0};
    tbl[3]  = '{8'h05, 8'h03, 3'd7, 16'h0005, 1'b0, 1, 0};
    tbl[4]  = '{8'h80, 8'h00, 3'd5, 16'h0080, 1'b0, 1, 0};
    tbl[5]  = '{8'hFB, 8'h00, 3'd5, 16'h0005, 1'b0, 1, 0};
    tbl[6]  = '{8'h0F, 8'h00, 3'd3, 16'h00F0, 1'b0, 1, 0};
    tbl[7]  = '{8'hA5, 8'h0F, 3'd4, 16'h00AA, 1'b0, 1, 0};
    tbl[8]  = '{8'h03, 8'h05, 3'd1, 16'h0002, 1'b0, 1, 0};
    tbl[9]  = '{8'h03, 8'h05, 3'd6, 16'h0001, 1'b0, 1, 0};
    tbl[10] = '{8'h03, 8'hF0, 3'd7, 16'h00F0, 1'b0, 1, 5};
    tbl[11] = '{8'hFF, 8'hFF, 3'd2, MUL_EN ? 16'hFE01 : 16'h0000, ~MUL_EN, MUL_EN ? 9 : 1, 0};
    tbl[12] = '{8'h0D, 8'hB3, 3'd2, MUL_EN ? 16'h0917 : 16'h0000, ~MUL_EN, MUL_EN ? 9 : 1, 5};
    tbl[13] = '{8'h00, 8'h00, 3'd0, 16'h0000, 1'b0, 1, 1};

    reset_n_i   = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    data_a_i    = 8'h00;
    data_b_i    = 8'h00;
    inst_i      = 3'd0;
    #12;
    check("reset_state", {in_ready_o, out_valid_o, err_o, data_o}, {1'b1, 1'b0, 1'b0, 16'h0000});
    @(negedge clk_p_i);
    reset_n_i = 1'b1;
    @(posedge clk_p_i); #1;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
             tbl[i].d, tbl[i].e, tbl[i].lat, tbl[i].hold);
    end

    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = $urandom;
      m   = model(int'(ra), int'(rb), int'(rop));
      run_op($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop, m[15:0], m[16],
             model_lat(int'(rop)), $urandom_range(0, 2));
    end

    // Reset four cycles into a multiply (or into DONE without the multiplier).
    data_a_i   = 8'hFF;
    data_b_i   = 8'hFF;
    inst_i     = 3'd2;
    in_valid_i = 1'b1;
    @(posedge clk_p_i); #1;
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk_p_i);
    #1;
    reset_n_i = 1'b0;
    #1;
    check("mid_op_reset_state", {in_ready_o, out_valid_o, err_o, data_o}, {1'b1, 1'b0, 1'b0, 16'h0000});
    @(negedge clk_p_i);
    reset_n_i = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk_p_i); #1;
      if (out_valid_o) seen = 1'b1;
    end
    check("abandoned_no_result", seen, 0);
    check("abandoned_idle", {in_ready_o, data_o}, {1'b1, 16'h0000});

    m = model(8'h12, 8'h34, 0);
    run_op("post_reset_add", 8'h12, 8'h34, 3'd0, m[15:0], m[16], 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
